// File: rtl/fruit_spawn_scheduler_pkg.sv
// Shared types, screen geometry, LFSR constants and spawn defaults for the
// fruit spawn scheduler and the motion / out-of-bound logic around it.
package fruit_spawn_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PICK = 2'd2,
        ST_LOAD = 2'd3
    } sched_state_e;

    // Screen geometry
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int CENTRE_X = 320;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (state bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Default spawn constants
    localparam int DEF_N_SLOTS      = 4;
    localparam int DEF_SPAWN_FRAMES = 45;
    localparam int DEF_GRACE_FRAMES = 8;
    localparam int DEF_X_MIN        = 64;
    localparam int DEF_INIT_Y       = 440;
    localparam int DEF_TX_BASE      = 200000;
    localparam int DEF_TX_STEP      = 50000;
    localparam int DEF_TY_BASE      = 100000;
    localparam int DEF_TY_STEP      = 25000;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    // Saturating add used by both score counters
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {13'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/fruit_spawn_scheduler_if.sv
// Broadcast spawn bus: one-hot load strobe plus the launch parameters that
// the addressed motion slot captures while its strobe is high.
interface fruit_spawn_scheduler_if #(
    parameter int N_SLOTS = 4
);
    logic [N_SLOTS-1:0] load_o;
    logic [9:0]         posx_o;
    logic [8:0]         posy_o;
    logic [31:0]        tx_o;
    logic [31:0]        ty_o;
    logic               dx_o;
    logic               dy_o;

    modport master (output load_o, posx_o, posy_o, tx_o, ty_o, dx_o, dy_o);
    modport slave  (input  load_o, posx_o, posy_o, tx_o, ty_o, dx_o, dy_o);
endinterface

// File: rtl/fruit_spawn_scheduler_spawn_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; a non-zero seed keeps it off the
// all-zero lock-up state.
module spawn_lfsr
    import fruit_spawn_scheduler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr_o
);
    logic [15:0] lfsr_r;

    // Advance one step every clock, regardless of scheduler state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    assign lfsr_o = lfsr_r;
endmodule

// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: periodically launches an object into the lowest
// free motion slot and retires slots on slice (hit) or out-of-bound (miss).
module fruit_spawn_scheduler
    import fruit_spawn_scheduler_pkg::*;
#(
    parameter int N_SLOTS      = DEF_N_SLOTS,
    parameter int SPAWN_FRAMES = DEF_SPAWN_FRAMES,
    parameter int GRACE_FRAMES = DEF_GRACE_FRAMES,
    parameter int X_MIN        = DEF_X_MIN,
    parameter int INIT_Y       = DEF_INIT_Y,
    parameter int TX_BASE      = DEF_TX_BASE,
    parameter int TX_STEP      = DEF_TX_STEP,
    parameter int TY_BASE      = DEF_TY_BASE,
    parameter int TY_STEP      = DEF_TY_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                frame_tick_i,
    input  logic [N_SLOTS-1:0]  oob_i,
    input  logic [N_SLOTS-1:0]  hit_i,
    fruit_spawn_scheduler_if.master bus,
    output logic [N_SLOTS-1:0]  active_o,
    output logic [15:0]         hit_cnt_o,
    output logic [15:0]         miss_cnt_o,
    output logic                stall_o
);
    localparam logic [15:0]        SPAWN_LAST = 16'(SPAWN_FRAMES - 1);
    localparam logic [7:0]         GRACE_INIT = 8'(GRACE_FRAMES);
    localparam logic [N_SLOTS-1:0] ONE_MASK   = N_SLOTS'(1);

    sched_state_e       state_r, state_nxt_s;
    logic [15:0]        frame_cnt_r, frame_cnt_nxt_s;
    logic [15:0]        lfsr_s;
    logic [N_SLOTS-1:0] active_r, free_s, hit_ev_s, miss_ev_s;
    logic [2:0]         low_idx_s, idx_r;
    logic               pick_go_s, load_go_s, stall_go_s;
    logic [9:0]         posx_s;
    logic [31:0]        tx_s, ty_s;
    logic [N_SLOTS-1:0] load_r;
    logic [9:0]         posx_r;
    logic [8:0]         posy_r;
    logic [31:0]        tx_r, ty_r;
    logic               dx_r, dy_r, stall_r;
    logic [15:0]        hit_cnt_r, miss_cnt_r;

    spawn_lfsr u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr_s)
    );

    assign free_s = ~active_r;

    // Lowest free slot index (scan from the top so the lowest wins)
    always_comb begin
        low_idx_s = 3'd0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            if (free_s[k]) begin
                low_idx_s = 3'(k);
            end else begin
                low_idx_s = low_idx_s;
            end
        end
    end

    // Launch parameters derived from the current LFSR value
    always_comb begin
        posx_s = 10'(X_MIN) + {1'b0, lfsr_s[8:0]};
        tx_s   = 32'(TX_BASE) + 32'(lfsr_s[12:9]) * 32'(TX_STEP);
        ty_s   = 32'(TY_BASE) + 32'(lfsr_s[15:13]) * 32'(TY_STEP);
    end

    // FSM state and frame counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            frame_cnt_r <= frame_cnt_nxt_s;
        end
    end

    // FSM next state and per-cycle control strobes
    always_comb begin
        state_nxt_s     = state_r;
        frame_cnt_nxt_s = frame_cnt_r;
        pick_go_s       = 1'b0;
        load_go_s       = 1'b0;
        stall_go_s      = 1'b0;
        if (!enable_i) begin
            state_nxt_s     = ST_IDLE;
            frame_cnt_nxt_s = 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s     = ST_WAIT;
                    frame_cnt_nxt_s = 16'd0;
                end
                ST_WAIT: begin
                    if (frame_tick_i) begin
                        if (frame_cnt_r == SPAWN_LAST) begin
                            state_nxt_s = ST_PICK;
                        end else begin
                            frame_cnt_nxt_s = frame_cnt_r + 16'd1;
                        end
                    end else begin
                        frame_cnt_nxt_s = frame_cnt_r;
                    end
                end
                ST_PICK: begin
                    if (free_s == '0) begin
                        // Keep the counter at its last value so the next tick retries
                        stall_go_s      = 1'b1;
                        frame_cnt_nxt_s = SPAWN_LAST;
                        state_nxt_s     = ST_WAIT;
                    end else begin
                        pick_go_s   = 1'b1;
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_go_s       = 1'b1;
                    frame_cnt_nxt_s = 16'd0;
                    state_nxt_s     = ST_WAIT;
                end
                default: begin
                    state_nxt_s     = ST_IDLE;
                    frame_cnt_nxt_s = 16'd0;
                end
            endcase
        end
    end

    // Spawn bus registers: captured on PICK->LOAD so the strobe is high exactly in LOAD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_r  <= '0;
            idx_r   <= 3'd0;
            posx_r  <= 10'd0;
            posy_r  <= 9'd0;
            tx_r    <= 32'd0;
            ty_r    <= 32'd0;
            dx_r    <= 1'b0;
            dy_r    <= 1'b0;
            stall_r <= 1'b0;
        end else begin
            stall_r <= stall_go_s;
            if (pick_go_s) begin
                load_r <= ONE_MASK << low_idx_s;
                idx_r  <= low_idx_s;
                posx_r <= posx_s;
                posy_r <= 9'(INIT_Y);
                tx_r   <= tx_s;
                ty_r   <= ty_s;
                dx_r   <= (posx_s < 10'(CENTRE_X));
                dy_r   <= 1'b0;
            end else begin
                load_r <= '0;
            end
        end
    end

    // Per-slot grace counter and in-flight flag
    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        logic [7:0] grace_r;
        logic       act_r;

        assign hit_ev_s[k]  = hit_i[k] & act_r;
        assign miss_ev_s[k] = oob_i[k] & act_r & (grace_r == 8'd0) & ~hit_i[k];
        assign active_r[k]  = act_r;

        // Arm on load, count grace down on frame ticks, clear on hit or miss
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grace_r <= 8'd0;
                act_r   <= 1'b0;
            end else if (!enable_i) begin
                grace_r <= 8'd0;
                act_r   <= 1'b0;
            end else if (load_go_s && (idx_r == 3'(k))) begin
                grace_r <= GRACE_INIT;
                act_r   <= 1'b1;
            end else begin
                if (frame_tick_i && (grace_r != 8'd0)) begin
                    grace_r <= grace_r - 8'd1;
                end else begin
                    grace_r <= grace_r;
                end
                act_r <= act_r & ~hit_ev_s[k] & ~miss_ev_s[k];
            end
        end
    end

    // Saturating score counters; they only clear on rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_r  <= 16'd0;
            miss_cnt_r <= 16'd0;
        end else if (enable_i) begin
            hit_cnt_r  <= sat_add16(hit_cnt_r, popcount8(8'(hit_ev_s)));
            miss_cnt_r <= sat_add16(miss_cnt_r, popcount8(8'(miss_ev_s)));
        end else begin
            hit_cnt_r  <= hit_cnt_r;
            miss_cnt_r <= miss_cnt_r;
        end
    end

    assign bus.load_o = load_r;
    assign bus.posx_o = posx_r;
    assign bus.posy_o = posy_r;
    assign bus.tx_o   = tx_r;
    assign bus.ty_o   = ty_r;
    assign bus.dx_o   = dx_r;
    assign bus.dy_o   = dy_r;
    assign active_o   = active_r;
    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;
    assign stall_o    = stall_r;
endmodule

// File: tb/tb_fruit_spawn_scheduler.sv
// Directed bench for fruit_spawn_scheduler with a load scoreboard and a
// reference LFSR for the launch parameters.
module tb_fruit_spawn_scheduler;
    import fruit_spawn_scheduler_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       enable_i;
    logic       frame_tick_i;
    logic [3:0] oob_i;
    logic [3:0] hit_i;
    logic [3:0] active_o;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;
    logic       stall_o;

    fruit_spawn_scheduler_if #(.N_SLOTS(4)) bus_if ();

    fruit_spawn_scheduler #(.N_SLOTS(4), .SPAWN_FRAMES(4), .GRACE_FRAMES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .frame_tick_i (frame_tick_i),
        .oob_i        (oob_i),
        .hit_i        (hit_i),
        .bus          (bus_if),
        .active_o     (active_o),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o),
        .stall_o      (stall_o)
    );

    int          n_checks;
    int          n_errors;
    int          stall_seen;
    logic [3:0]  sb_q[$];
    logic [15:0] m_cur, m_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev is the value the DUT saw at the last edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cur  <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_cur;
            m_cur  <= {m_cur[14:0], m_cur[15] ^ m_cur[13] ^ m_cur[12] ^ m_cur[10]};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop and bus check whenever a load strobe is seen
    task automatic monitor();
        logic [3:0]  exp_load;
        logic [15:0] snap;
        logic [9:0]  exp_x;
        if (rst_n && stall_o) stall_seen++;
        if (rst_n && (bus_if.load_o != 4'd0)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_load", 32'(bus_if.load_o), 32'd0);
            end else begin
                exp_load = sb_q.pop_front();
                snap     = m_prev;
                exp_x    = 10'd64 + {1'b0, snap[8:0]};
                chk("load_mask", 32'(bus_if.load_o), 32'(exp_load));
                chk("posx", 32'(bus_if.posx_o), 32'(exp_x));
                chk("posx_range", 32'((bus_if.posx_o >= 10'd64) && (bus_if.posx_o <= 10'd575)), 32'd1);
                chk("posy", 32'(bus_if.posy_o), 32'd440);
                chk("tx", bus_if.tx_o, 32'd200000 + 32'(snap[12:9]) * 32'd50000);
                chk("ty", bus_if.ty_o, 32'd100000 + 32'(snap[15:13]) * 32'd25000);
                chk("dx", 32'(bus_if.dx_o), 32'(exp_x < 10'd320));
                chk("dy", 32'(bus_if.dy_o), 32'd0);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
    endtask

    // One frame tick followed by nine idle clocks
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            frame_tick_i = 1'b1;
            step();
            frame_tick_i = 1'b0;
            repeat (8) step();
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0; stall_seen = 0;
        rst_n = 1'b0; enable_i = 1'b0; frame_tick_i = 1'b0;
        oob_i = 4'd0; hit_i = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_load", 32'(bus_if.load_o), 32'd0);
        chk("rst_posx", 32'(bus_if.posx_o), 32'd0);
        chk("rst_active", 32'(active_o), 32'd0);
        chk("rst_hit", 32'(hit_cnt_o), 32'd0);
        chk("rst_miss", 32'(miss_cnt_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));

        // 1: first spawn two clocks after the 4th tick
        rst_n = 1'b1;
        enable_i = 1'b1;
        sb_q.push_back(4'b0001);
        tick_n(3);
        step();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        chk("t1_no_load_in_pick", 32'(bus_if.load_o), 32'd0);
        step();
        chk("t1_load_slot0", 32'(bus_if.load_o), 32'b0001);
        repeat (8) step();
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("t1_active", 32'(active_o), 32'b0001);

        // 2: fill all slots, then stall once per tick, then a hit frees slot 2
        sb_q.push_back(4'b0010);
        sb_q.push_back(4'b0100);
        sb_q.push_back(4'b1000);
        tick_n(12);
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("t2_all_active", 32'(active_o), 32'b1111);
        stall_seen = 0;
        tick_n(4);
        chk("t2_stall_first", 32'(stall_seen), 32'd1);
        tick_n(1);
        chk("t2_stall_retry", 32'(stall_seen), 32'd2);
        step();
        hit_i = 4'b0100;
        step();
        hit_i = 4'b0000;
        step();
        chk("t2_active_after_hit", 32'(active_o), 32'b1011);
        chk("t2_hit_cnt", 32'(hit_cnt_o), 32'd1);
        sb_q.push_back(4'b0100);
        tick_n(1);
        chk("t2_refill_sb", 32'(sb_q.size()), 32'd0);
        chk("t2_refill_active", 32'(active_o), 32'b1111);

        // 3: hit beats oob on slot 0, then oob held through grace produces one miss
        step();
        hit_i = 4'b0001;
        oob_i = 4'b0001;
        step();
        hit_i = 4'b0000;
        step();
        chk("t3_hit_cnt", 32'(hit_cnt_o), 32'd2);
        chk("t3_miss_cnt0", 32'(miss_cnt_o), 32'd0);
        chk("t3_active", 32'(active_o), 32'b1110);
        sb_q.push_back(4'b0001);
        tick_n(4);
        chk("t3_reload_sb", 32'(sb_q.size()), 32'd0);
        tick_n(7);
        chk("t3_grace_active", 32'(active_o), 32'b1111);
        chk("t3_grace_miss", 32'(miss_cnt_o), 32'd0);
        tick_n(1);
        chk("t3_retired", 32'(active_o), 32'b1110);
        chk("t3_miss_cnt", 32'(miss_cnt_o), 32'd1);
        oob_i = 4'b0000;
        sb_q.push_back(4'b0001);
        tick_n(1);
        chk("t3_retry_sb", 32'(sb_q.size()), 32'd0);
        tick_n(8);

        // 4: two hits plus oob on a hit slot in one cycle
        step();
        hit_i = 4'b0011;
        oob_i = 4'b0001;
        step();
        hit_i = 4'b0000;
        oob_i = 4'b0000;
        step();
        chk("t4_hit_cnt", 32'(hit_cnt_o), 32'd4);
        chk("t4_miss_cnt", 32'(miss_cnt_o), 32'd1);
        chk("t4_active", 32'(active_o), 32'b1100);

        // 5: enable drops while in PICK
        step();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        chk("t5_in_pick", 32'(dut.state_r), 32'(ST_PICK));
        enable_i = 1'b0;
        step();
        chk("t5_no_load", 32'(bus_if.load_o), 32'd0);
        chk("t5_active_clr", 32'(active_o), 32'd0);
        chk("t5_idle", 32'(dut.state_r), 32'(ST_IDLE));
        chk("t5_hit_hold", 32'(hit_cnt_o), 32'd4);
        chk("t5_miss_hold", 32'(miss_cnt_o), 32'd1);
        step();
        enable_i = 1'b1;
        sb_q.push_back(4'b0001);
        tick_n(3);
        chk("t5_full_wait", 32'(sb_q.size()), 32'd1);
        tick_n(1);
        chk("t5_reload_sb", 32'(sb_q.size()), 32'd0);

        // 6: hit counter saturation, then async reset during LOAD
        sb_q.push_back(4'b0010);
        tick_n(4);
        chk("t6_sb", 32'(sb_q.size()), 32'd0);
        step();
        force dut.hit_cnt_r = 16'hFFFE;
        #1;
        release dut.hit_cnt_r;
        hit_i = 4'b0011;
        step();
        hit_i = 4'b0000;
        step();
        chk("t6_hit_sat", 32'(hit_cnt_o), 32'h0000FFFF);
        chk("t6_active", 32'(active_o), 32'd0);
        sb_q.push_back(4'b0001);
        tick_n(3);
        step();
        frame_tick_i = 1'b1;
        step();
        frame_tick_i = 1'b0;
        step();
        chk("t6_in_load", 32'(bus_if.load_o), 32'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_load", 32'(bus_if.load_o), 32'd0);
        chk("t6_rst_posx", 32'(bus_if.posx_o), 32'd0);
        chk("t6_rst_posy", 32'(bus_if.posy_o), 32'd0);
        chk("t6_rst_tx", bus_if.tx_o, 32'd0);
        chk("t6_rst_ty", bus_if.ty_o, 32'd0);
        chk("t6_rst_dx", 32'(bus_if.dx_o), 32'd0);
        chk("t6_rst_active", 32'(active_o), 32'd0);
        chk("t6_rst_hit", 32'(hit_cnt_o), 32'd0);
        chk("t6_rst_miss", 32'(miss_cnt_o), 32'd0);
        chk("t6_rst_stall", 32'(stall_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
